// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: data word and register-address types.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/register_file.sv
// RV32I integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero on both write and read paths.
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] AD1,
  input  logic [$clog2(NREGS)-1:0] AD2,
  input  logic                     WE,
  input  logic [$clog2(NREGS)-1:0] AD3,
  input  logic [XLEN-1:0]          WD3,
  output logic [XLEN-1:0]          RD1,
  output logic [XLEN-1:0]          RD2
);

  import rv_pkg::*;

  logic [XLEN-1:0] regs [NREGS];

  // A read of x0 is forced to zero here as well, so entry 0 never leaks
  // regardless of what the storage holds.
  function automatic logic [XLEN-1:0] read_port(input logic [$clog2(NREGS)-1:0] addr);
    if (addr == REG_ZERO) begin
      return '0;
    end
    return regs[addr];
  endfunction

  // Storage: async clear, then write rd on the rising edge unless it is x0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (WE && (AD3 != REG_ZERO)) begin
      regs[AD3] <= WD3;
    end
  end

  // Both read ports are plain muxes with no write bypass.
  always_comb begin
    RD1 = read_port(AD1);
    RD2 = read_port(AD2);
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, hand-written
// reset / read-during-write sequences, a full sweep and a randomized phase
// against an array-based reference model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  AD1, AD2, AD3;
  logic        WE;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2;

  logic [31:0] model [32];
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [4:0]  ad3;
    logic [31:0] wd3;
    logic [4:0]  ad1;
    logic [4:0]  ad2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [9];

  register_file #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .AD1   (AD1),
    .AD2   (AD2),
    .WE    (WE),
    .AD3   (AD3),
    .WD3   (WD3),
    .RD1   (RD1),
    .RD2   (RD2)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] e1, input logic [31:0] e2);
    checks++;
    if (RD1 !== e1) begin
      errors++;
      $display("[TB] FAIL %s RD1: got %h expected %h", name, RD1, e1);
    end
    checks++;
    if (RD2 !== e2) begin
      errors++;
      $display("[TB] FAIL %s RD2: got %h expected %h", name, RD2, e2);
    end
  endtask

  // Drive on the falling edge, let one rising edge happen, mirror the
  // architectural write rule in the model, then settle 1 ns past the edge.
  task automatic applyStimulus(input logic we, input logic [4:0] ad3, input logic [31:0] wd3,
                               input logic [4:0] ad1, input logic [4:0] ad2);
    @(negedge clk);
    WE = we; AD3 = ad3; WD3 = wd3; AD1 = ad1; AD2 = ad2;
    @(posedge clk);
    if (rst_n === 1'b1 && we === 1'b1 && ad3 != 5'd0) model[ad3] = wd3;
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd10, 32'd14,        5'd10, 5'd10, 32'd14,        32'd14};
    vecs[1] = '{1'b0, 5'd10, 'x,            5'd10, 5'd10, 32'd14,        32'd14};
    vecs[2] = '{1'b0, 'x,    'x,            5'd10, 5'd10, 32'd14,        32'd14};
    vecs[3] = '{1'b1, 5'd0,  32'hDEADBEEF,  5'd0,  5'd10, 32'h0,         32'd14};
    vecs[4] = '{1'b1, 5'd1,  32'hDEADBEEF,  5'd1,  5'd0,  32'hDEADBEEF,  32'h0};
    vecs[5] = '{1'b1, 5'd7,  32'h55,        5'd7,  5'd1,  32'h55,        32'hDEADBEEF};
    vecs[6] = '{1'b0, 5'd7,  32'hAAAAAAAA,  5'd7,  5'd7,  32'h55,        32'h55};
    vecs[7] = '{1'b0, 5'd7,  32'hAAAAAAAA,  5'd7,  5'd10, 32'h55,        32'd14};
    vecs[8] = '{1'b1, 5'd3,  32'h11,        5'd3,  5'd7,  32'h11,        32'h55};

    rst_n = 1'b1; WE = 1'b0; AD1 = 5'd5; AD2 = 5'd31; AD3 = 5'd0; WD3 = 32'h0;
    clearModel();

    // Reset asserted mid-cycle, before any clock edge: clears at once
    #3 rst_n = 1'b0;
    #1 checkOutput("reset_async_clear", 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("after_reset_5_31", 32'h0, 32'h0);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].we, vecs[i].ad3, vecs[i].wd3, vecs[i].ad1, vecs[i].ad2);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp1, vecs[i].exp2);
    end

    // Stable read over three more idle cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 'x, 'x, 5'd10, 5'd10);
      checkOutput("hold_reg10", 32'd14, 32'd14);
    end

    // Read-during-write: old value before the edge, new value after
    @(negedge clk);
    WE = 1'b1; AD3 = 5'd3; WD3 = 32'h22; AD1 = 5'd3; AD2 = 5'd3;
    #1 checkOutput("rdw_before_edge", 32'h11, 32'h11);
    @(posedge clk); model[3] = 32'h22;
    #1 checkOutput("rdw_after_edge", 32'h22, 32'h22);

    // Async reset after a write, mid-cycle; writes during reset ignored
    @(negedge clk);
    WE = 1'b1; AD3 = 5'd9; WD3 = 32'h99; AD1 = 5'd3; AD2 = 5'd7;
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_mid_cycle", 32'h0, 32'h0);
    @(posedge clk); #1;
    AD1 = 5'd9;
    #1 checkOutput("write_during_reset", 32'h0, 32'h0);
    @(negedge clk) begin rst_n = 1'b1; WE = 1'b0; end
    clearModel();

    // Full sweep: reg[i] = i * 0x01010101, then read (i, 31-i)
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      WE = 1'b0; AD1 = 5'(i); AD2 = 5'(31 - i);
      #1 checkOutput($sformatf("sweep_%0d", i), 32'(i) * 32'h01010101, 32'(31 - i) * 32'h01010101);
    end

    // Randomized traffic against the array model
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [4:0]  a1, a2, a3;
      logic [31:0] wd;
      we = 1'($urandom_range(0, 1));
      a1 = 5'($urandom); a2 = 5'($urandom); a3 = 5'($urandom);
      wd = $urandom;
      if (n % 5 == 0) a1 = a3;
      @(negedge clk);
      WE = we; AD3 = a3; WD3 = wd; AD1 = a1; AD2 = a2;
      #1 checkOutput("rand_pre_edge", (a1 == 0) ? 32'h0 : model[a1], (a2 == 0) ? 32'h0 : model[a2]);
      @(posedge clk);
      if (we && a3 != 0) model[a3] = wd;
      #1 checkOutput("rand_post_edge", (a1 == 0) ? 32'h0 : model[a1], (a2 == 0) ? 32'h0 : model[a2]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
